// File: rtl/csa_resolve.sv
`default_nettype none
// ============================================================================
// Module   : csa_resolve
// Brief    : Resolves a carry-save (C,S) limb vector into radix-2^OUT_W limbs,
//            LPC limbs per cycle, carrying a 6-bit carry between cycles.
// Revision : 1.0
// ============================================================================
module csa_resolve #(
    parameter int NUM_LIMBS = 99,
    parameter int IN_W      = 20,
    parameter int OUT_W     = 16,
    parameter int LPC       = 9
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_LIMBS-1:0][IN_W-1:0]   C,
    input  logic [NUM_LIMBS-1:0][IN_W-1:0]   S,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_LIMBS-1:0][OUT_W-1:0]  R,
    output logic [5:0]                       R_cout
);

    localparam int c_CW     = 6;
    localparam int c_T_W    = OUT_W + c_CW;
    localparam int c_IDX_W  = $clog2(NUM_LIMBS + LPC + 1);
    localparam int c_LIMB_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    localparam logic [c_IDX_W-1:0] c_NUM = c_IDX_W'(NUM_LIMBS);
    localparam logic [c_IDX_W-1:0] c_LPC = c_IDX_W'(LPC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                            r_in_ready;
    logic                            r_out_valid;
    logic [c_IDX_W-1:0]              r_idx;
    logic [c_CW-1:0]                 r_carry;
    logic [c_CW-1:0]                 r_cout;
    logic [NUM_LIMBS-1:0][OUT_W-1:0] r_r;
    logic [NUM_LIMBS-1:0][IN_W-1:0]  r_c;
    logic [NUM_LIMBS-1:0][IN_W-1:0]  r_s;

    logic                            w_accept;
    logic                            w_last;
    logic [NUM_LIMBS-1:0][OUT_W-1:0] w_r_next;
    logic [c_CW-1:0]                 w_run_carry;
    logic [c_IDX_W-1:0]              w_pos;
    logic [c_LIMB_W-1:0]             w_limb;
    logic [c_T_W-1:0]                w_t;

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_state == S_RUN) && ((r_idx + c_LPC) >= c_NUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Ripple chain over this cycle's window; limbs past the top pass the carry through untouched.
    always_comb begin
        w_r_next    = r_r;
        w_run_carry = r_carry;
        w_pos       = '0;
        w_limb      = '0;
        w_t         = '0;
        for (int j = 0; j < LPC; j++) begin
            w_pos = r_idx + c_IDX_W'(j);
            if ((r_state == S_RUN) && (w_pos < c_NUM)) begin
                w_limb           = w_pos[c_LIMB_W-1:0];
                w_t              = c_T_W'(r_c[w_limb]) + c_T_W'(r_s[w_limb]) + c_T_W'(w_run_carry);
                w_r_next[w_limb] = w_t[OUT_W-1:0];
                w_run_carry      = w_t[c_T_W-1:OUT_W];
            end
        end
    end

    // Handshake flags are registered so both read low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_carry     <= '0;
            r_cout      <= '0;
            r_r         <= '0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_idx   <= '0;
                r_carry <= '0;
            end else if (r_state == S_RUN) begin
                r_idx   <= r_idx + c_LPC;
                r_carry <= w_run_carry;
                r_r     <= w_r_next;
                if (w_last) begin
                    r_cout <= w_run_carry;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_c <= C;
            r_s <= S;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign R         = r_r;
    assign R_cout    = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_resolve
// Brief    : Directed and random checks of csa_resolve at LPC=9 and LPC=7
//            against a big-integer sum model.
// Revision : 1.0
// ============================================================================
module tb_csa_resolve;

    localparam int N     = 99;
    localparam int IW    = 20;
    localparam int OW    = 16;
    localparam int MW    = OW * N + 8;
    localparam int NRAND = 1000;

    typedef logic [N-1:0][IW-1:0] cvec_t;
    typedef logic [N-1:0][OW-1:0] rvec_t;

    logic  clk;
    logic  rst_n;
    logic  in_valid  [2];
    logic  in_ready  [2];
    logic  out_valid [2];
    logic  out_ready [2];
    cvec_t c_in      [2];
    cvec_t s_in      [2];
    rvec_t r_out     [2];
    logic [5:0] cout [2];

    int checks   = 0;
    int failures = 0;
    int n_acc [2] = '{0, 0};
    int n_out [2] = '{0, 0};

    csa_resolve #(.NUM_LIMBS(N), .IN_W(IW), .OUT_W(OW), .LPC(9)) u_dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .C(c_in[0]), .S(s_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .R(r_out[0]), .R_cout(cout[0])
    );

    csa_resolve #(.NUM_LIMBS(N), .IN_W(IW), .OUT_W(OW), .LPC(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .C(c_in[1]), .S(s_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .R(r_out[1]), .R_cout(cout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (in_valid[d] && in_ready[d])   n_acc[d]++;
            if (out_valid[d] && out_ready[d]) n_out[d]++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Golden value: the whole operand as one big integer sum.
    function automatic logic [MW-1:0] model(input cvec_t c, input cvec_t s);
        logic [MW-1:0] acc;
        acc = '0;
        for (int m = 0; m < N; m++)
            acc = acc + ((MW'(c[m]) + MW'(s[m])) << (OW * m));
        return acc;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? (N + 8) / 9 : (N + 6) / 7;
    endfunction

    function automatic cvec_t rnd_vec(input int mode);
        cvec_t v;
        for (int m = 0; m < N; m++) begin
            case (mode)
                1:       v[m] = ($urandom_range(0, 3) != 0) ? {IW{1'b1}} : IW'($urandom);
                2:       v[m] = ($urandom_range(0, 7) == 0) ? IW'($urandom) : '0;
                default: v[m] = IW'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input int d, input logic [MW-1:0] exp);
        rvec_t robs;
        int    bad;
        robs = r_out[d];
        bad  = 0;
        for (int m = N - 1; m >= 0; m--)
            if (robs[m] !== exp[m*OW +: OW]) bad = m;
        checks++;
        assert (robs === exp[OW*N-1:0]) else begin
            failures++;
            $error("FAIL %s dut=%0d limb=%0d observed=%0h expected=%0h",
                   tag, d, bad, robs[bad], exp[bad*OW +: OW]);
        end
        checks++;
        assert (cout[d] === exp[OW*N +: 6]) else begin
            failures++;
            $error("FAIL %s_cout dut=%0d observed=%0h expected=%0h", tag, d, cout[d], exp[OW*N +: 6]);
        end
    endtask

    task automatic send(input int d, input cvec_t c, input cvec_t s);
        int k;
        k = 0;
        c_in[d] = c; s_in[d] = s; in_valid[d] = 1'b1;
        while (in_ready[d] !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        chk("accept_wait", 64'(k < 64), 64'd1);
        tick();
        in_valid[d] = 1'b0;
        c_in[d] = rnd_vec(0);
        s_in[d] = rnd_vec(0);
    endtask

    // Optionally keeps in_valid high with junk data while busy; it must be ignored.
    task automatic wait_out(input int d, input bit busy_valid, output int lat);
        lat = 0;
        in_valid[d] = busy_valid;
        while (out_valid[d] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic release_out(input int d);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
    endtask

    // Leaves the DUT in DONE with the result checked; caller releases it.
    task automatic run_op(input string tag, input int d, input cvec_t c, input cvec_t s,
                          input int hold, input bit busy_valid);
        logic [MW-1:0] exp;
        int lat;
        exp = model(c, s);
        send(d, c, s);
        wait_out(d, busy_valid, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(lat_of(d)));
        repeat (hold) tick();
        chk({tag, "_valid"}, 64'(out_valid[d]), 64'd1);
        chk_r(tag, d, exp);
    endtask

    initial begin
        cvec_t a, b, z, ones;
        logic [MW-1:0] exp_a;
        int lat, seen, a0, o0;

        z    = '0;
        ones = '1;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0; c_in[d] = '0; s_in[d] = '0;
        end

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", 64'(in_ready[d]), 64'd0);
            chk("reset_out_valid", 64'(out_valid[d]), 64'd0);
            chk_r("reset_r", d, '0);
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) chk("post_reset_in_ready", 64'(in_ready[d]), 64'd1);

        // Directed operands on both widths
        for (int d = 0; d < 2; d++) begin
            run_op("zero", d, z, z, 0, 1'b0);
            release_out(d);

            a = '0; b = '0;
            a[0] = 20'hFFFFF; b[0] = 20'h00001;
            run_op("low_carry", d, a, b, 0, 1'b0);
            chk("low_carry_limb0", 64'(r_out[d][0]), 64'h0);
            chk("low_carry_limb1", 64'(r_out[d][1]), 64'h10);
            release_out(d);

            run_op("all_ones", d, ones, ones, 0, 1'b0);
            chk("all_ones_cout_nonzero", 64'(cout[d] != 6'd0), 64'd1);
            release_out(d);
        end

        // Back-pressure in DONE: result stable, new request ignored until released
        a = rnd_vec(0); b = rnd_vec(1);
        exp_a = model(a, a);
        send(0, a, a);
        wait_out(0, 1'b0, lat);
        chk("hold_latency", 64'(lat), 64'(lat_of(0)));
        c_in[0] = b; s_in[0] = b; in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(out_valid[0]), 64'd1);
            chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
            chk_r("hold_r", 0, exp_a);
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("hold_idle_ready", 64'(in_ready[0]), 64'd1);
        chk("hold_idle_valid", 64'(out_valid[0]), 64'd0);
        tick();
        in_valid[0] = 1'b0;
        chk("hold_accepted", 64'(in_ready[0]), 64'd0);
        wait_out(0, 1'b0, lat);
        chk("hold_next_latency", 64'(lat), 64'(lat_of(0)));
        chk_r("hold_next", 0, model(b, b));
        release_out(0);

        // Reset during RUN cycle 4 discards the operand
        a = rnd_vec(1);
        send(0, a, a);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_valid", 64'(out_valid[0]), 64'd0);
        chk("midrun_reset_ready", 64'(in_ready[0]), 64'd0);
        chk_r("midrun_reset_r", 0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid[0] === 1'b1) seen = 1;
            tick();
        end
        chk("midrun_no_output", 64'(seen), 64'd0);
        a = rnd_vec(0); b = rnd_vec(2);
        run_op("after_reset", 0, a, b, 1, 1'b0);
        release_out(0);

        // Random operands with random gaps and back-pressure
        for (int d = 0; d < 2; d++) begin
            a0 = n_acc[d];
            o0 = n_out[d];
            for (int i = 0; i < NRAND; i++) begin
                a = rnd_vec($urandom_range(0, 2));
                b = rnd_vec($urandom_range(0, 2));
                run_op("random", d, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                release_out(d);
                repeat ($urandom_range(0, 2)) tick();
            end
            chk("random_accepts", 64'(n_acc[d] - a0), 64'(NRAND));
            chk("random_outputs", 64'(n_out[d] - o0), 64'(NRAND));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
